// File: rtl/adc_capture_logic.sv
// Purpose : register-mapped IPIF slave that clocks a 10-bit parallel ADC, captures samples at a programmable rate into a 16-entry FIFO and drains them through bus reads.
// Latency : capture lands in the FIFO on the edge ending each sample period; reads are combinational and ack in the same cycle.
// Backpres: none toward the ADC -- a capture into a full FIFO with no pop that cycle is dropped and sets the sticky overflow flag.
//
// Ports:
//   Bus2IP_Clk / Bus2IP_Reset      single clock, synchronous active-high reset
//   ADC2IP_Data                    ADC parallel sample (straight binary)
//   IP2ADC_Clk / IP2ADC_PWRDN      registered ADC conversion clock and power-down (high = off)
//   Bus2IP_Data/BE/RdCE/WrCE       IPIF write data, byte enables, one-hot chip enables (bit1 = REG0, bit0 = REG1)
//   IP2Bus_Data/RdAck/WrAck/Error  read data and same-cycle acks; error never raised
module adc_capture_logic #(
    parameter int C_NUM_REG         = 2,
    parameter int C_SLV_DWIDTH      = 32,
    parameter int C_ADC_WIDTH       = 10,
    parameter int C_FIFO_DEPTH_LOG2 = 4
) (
    input  logic                      Bus2IP_Clk,
    input  logic                      Bus2IP_Reset,
    input  logic [C_ADC_WIDTH-1:0]    ADC2IP_Data,
    output logic                      IP2ADC_Clk,
    output logic                      IP2ADC_PWRDN,
    input  logic [C_SLV_DWIDTH-1:0]   Bus2IP_Data,
    input  logic [C_SLV_DWIDTH/8-1:0] Bus2IP_BE,
    input  logic [C_NUM_REG-1:0]      Bus2IP_RdCE,
    input  logic [C_NUM_REG-1:0]      Bus2IP_WrCE,
    output logic [C_SLV_DWIDTH-1:0]   IP2Bus_Data,
    output logic                      IP2Bus_RdAck,
    output logic                      IP2Bus_WrAck,
    output logic                      IP2Bus_Error
);

    localparam int AW    = C_FIFO_DEPTH_LOG2;
    localparam int DEPTH = 1 << AW;

    // control / timer state
    logic                   en;
    logic [7:0]             div;
    logic [7:0]             cnt;
    logic                   ovf;

    // sample FIFO
    logic [C_ADC_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [AW:0]            count;

    logic                   wr_reg0, rd_reg0, rd_reg1;
    logic                   en_nxt, clr;
    logic [7:0]             div_nxt, d_cur, d_nxt, cnt_nxt;
    logic [8:0]             half_nxt;
    logic                   capture, empty, full, push, pop, drop;
    logic                   unused_ok;

    assign wr_reg0 = Bus2IP_WrCE[1];
    assign rd_reg0 = Bus2IP_RdCE[1];
    assign rd_reg1 = Bus2IP_RdCE[0];

    // Writes to REG0 take effect on the write edge; CLR is gated by the low byte enable.
    assign en_nxt  = (wr_reg0 && Bus2IP_BE[0]) ? Bus2IP_Data[0]    : en;
    assign div_nxt = (wr_reg0 && Bus2IP_BE[1]) ? Bus2IP_Data[15:8] : div;
    assign clr     = wr_reg0 && Bus2IP_BE[0] && Bus2IP_Data[1];

    // A divider of zero behaves as one so the ADC clock never stalls.
    assign d_cur    = (div == 8'd0)     ? 8'd1 : div;
    assign d_nxt    = (div_nxt == 8'd0) ? 8'd1 : div_nxt;
    assign half_nxt = ({1'b0, d_nxt} + 9'd1) >> 1;

    // The counter only advances once EN was already set, so the first period after
    // enabling starts cleanly at zero. A counter left above a freshly lowered divider
    // wraps on its next edge; capture requires an exact match, so that wrap never samples.
    assign capture = en && (cnt == d_cur);
    assign cnt_nxt = (en && en_nxt) ? ((cnt >= d_cur) ? 8'd0 : cnt + 8'd1) : 8'd0;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign pop   = rd_reg1 && !empty;
    assign push  = capture && (!full || pop);
    assign drop  = capture && full && !pop;

    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            en           <= 1'b0;
            div          <= 8'd0;
            cnt          <= 8'd0;
            ovf          <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            IP2ADC_Clk   <= 1'b0;
            IP2ADC_PWRDN <= 1'b1;
        end else begin
            en           <= en_nxt;
            div          <= div_nxt;
            cnt          <= cnt_nxt;
            // Decoded from next-state values so the pin tracks the counter register exactly.
            IP2ADC_Clk   <= en_nxt && ({1'b0, cnt_nxt} < half_nxt);
            IP2ADC_PWRDN <= ~en_nxt;
            if (clr) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                ovf    <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
                if (drop) ovf <= 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge Bus2IP_Clk) begin
        if (push) mem[wr_ptr] <= ADC2IP_Data;
    end

    always_comb begin
        IP2Bus_Data = '0;
        if (rd_reg0) begin
            IP2Bus_Data[0]             = en;
            IP2Bus_Data[2]             = ovf;
            IP2Bus_Data[3]             = empty;
            IP2Bus_Data[4]             = full;
            IP2Bus_Data[15:8]          = div;
            IP2Bus_Data[16 +: AW+1]    = count;
        end
        if (rd_reg1 && !empty) begin
            IP2Bus_Data[C_SLV_DWIDTH-1]  = 1'b1;
            IP2Bus_Data[C_ADC_WIDTH-1:0] = IP2Bus_Data[C_ADC_WIDTH-1:0] | mem[rd_ptr];
        end
    end

    assign IP2Bus_RdAck = |Bus2IP_RdCE;
    assign IP2Bus_WrAck = |Bus2IP_WrCE;
    assign IP2Bus_Error = 1'b0;

    assign unused_ok = ^{Bus2IP_Data[C_SLV_DWIDTH-1:16], Bus2IP_Data[7:2], Bus2IP_BE[C_SLV_DWIDTH/8-1:2]};

endmodule

// File: tb/tb_adc_capture_logic.sv
// Purpose : directed bench for adc_capture_logic with hand-computed register images and sample values.
// Latency : inputs driven 1 ns after the rising edge, outputs sampled on the falling edge.
// Backpres: n/a -- every wait is a fixed number of clock cycles.
module tb_adc_capture_logic;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  adc = '0;
    logic        adc_clk, pwrdn;
    logic [31:0] wdat = '0;
    logic [3:0]  be = '0;
    logic [1:0]  rdce = '0;
    logic [1:0]  wrce = '0;
    logic [31:0] rdat;
    logic        rdack, wrack, err;
    logic [31:0] r;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    adc_capture_logic dut (
        .Bus2IP_Clk   (clk),
        .Bus2IP_Reset (rst),
        .ADC2IP_Data  (adc),
        .IP2ADC_Clk   (adc_clk),
        .IP2ADC_PWRDN (pwrdn),
        .Bus2IP_Data  (wdat),
        .Bus2IP_BE    (be),
        .Bus2IP_RdCE  (rdce),
        .Bus2IP_WrCE  (wrce),
        .IP2Bus_Data  (rdat),
        .IP2Bus_RdAck (rdack),
        .IP2Bus_WrAck (wrack),
        .IP2Bus_Error (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        rdce = '0;
        wrce = '0;
        be   = '0;
        repeat (5) tick();
        rst  = 1'b0;
    endtask

    // Write occupies exactly one edge; returns 1 ns after it.
    task automatic bus_write(input logic [1:0] ce, input logic [31:0] dat, input logic [3:0] b);
        wrce = ce;
        wdat = dat;
        be   = b;
        @(negedge clk);
        check("wr_ack", {31'b0, wrack}, 32'd1);
        tick();
        wrce = '0;
        be   = '0;
        wdat = '0;
    endtask

    // Read shows the state left by the previous edge, then consumes one edge.
    task automatic bus_read(input logic [1:0] ce, output logic [31:0] d);
        rdce = ce;
        @(negedge clk);
        d = rdat;
        check("rd_ack", {31'b0, rdack}, 32'd1);
        tick();
        rdce = '0;
    endtask

    initial begin : stim
        logic [31:0] exp_reg0 [5];
        logic        exp_clk  [5];

        // ---- 1: reset state ----
        do_reset();
        @(negedge clk);
        check("t1_pwrdn", {31'b0, pwrdn},   32'd1);
        check("t1_adcclk", {31'b0, adc_clk}, 32'd0);
        check("t1_error", {31'b0, err},     32'd0);
        check("t1_idle_rdack", {31'b0, rdack}, 32'd0);
        check("t1_idle_wrack", {31'b0, wrack}, 32'd0);
        tick();
        bus_read(2'b10, r);
        check("t1_reg0", r, 32'h0000_0008);
        bus_read(2'b01, r);
        check("t1_reg1_empty", r, 32'h0000_0000);
        bus_write(2'b01, 32'hFFFF_FFFF, 4'hF);
        bus_read(2'b10, r);
        check("t1_reg1_wr_ignored", r, 32'h0000_0008);

        // ---- 2: EN with DIV=3, clock shape and first capture ----
        do_reset();
        adc = 10'h155;
        bus_write(2'b10, 32'h0000_0301, 4'hF);
        exp_clk  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        exp_reg0 = '{32'h0000_0309, 32'h0000_0309, 32'h0000_0309, 32'h0000_0309, 32'h0001_0301};
        rdce = 2'b10;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) check("t2_pwrdn", {31'b0, pwrdn}, 32'd0);
            check("t2_adcclk", {31'b0, adc_clk}, {31'b0, exp_clk[k]});
            check("t2_reg0", rdat, exp_reg0[k]);
            if (k < 4) @(posedge clk);
        end
        tick();
        rdce = '0;
        bus_read(2'b01, r);
        check("t2_reg1", r, 32'h8000_0155);
        bus_read(2'b10, r);
        check("t2_count_dec", r, 32'h0000_0309);

        // ---- 3: DIV=1 ramp, fill, overflow, drain in order ----
        do_reset();
        bus_write(2'b10, 32'h0000_0101, 4'hF);
        adc = 10'h100;
        for (int j = 1; j <= 40; j++) begin
            tick();
            adc = 10'(10'h100 + j);
        end
        bus_write(2'b10, 32'h0000_0100, 4'hF);
        bus_read(2'b10, r);
        check("t3_full_ovf", r, 32'h0010_0114);
        for (int k = 1; k <= 16; k++) begin
            bus_read(2'b01, r);
            check("t3_drain", r, 32'h8000_0000 | 32'(10'h0FF + 2 * k));
        end
        bus_read(2'b01, r);
        check("t3_read17", r, 32'h0000_0000);
        bus_read(2'b10, r);
        check("t3_after_drain", r, 32'h0000_010C);

        // ---- 4: pop on the capture edge while full ----
        do_reset();
        adc = 10'h2AA;
        bus_write(2'b10, 32'h0000_0101, 4'hF);
        repeat (33) tick();
        bus_read(2'b01, r);
        check("t4_head", r, 32'h8000_02AA);
        bus_read(2'b10, r);
        check("t4_no_ovf", r, 32'h0010_0111);
        tick();
        bus_read(2'b10, r);
        check("t4_ovf_set", r, 32'h0010_0115);

        // ---- 5: CLR with 5 samples held ----
        do_reset();
        bus_write(2'b10, 32'h0000_0301, 4'hF);
        repeat (20) tick();
        bus_read(2'b10, r);
        check("t5_five", r, 32'h0005_0301);
        bus_write(2'b10, 32'h0000_0303, 4'hF);
        bus_read(2'b10, r);
        check("t5_cleared", r, 32'h0000_0309);
        bus_read(2'b10, r);
        check("t5_still_empty", r, 32'h0000_0309);
        bus_read(2'b10, r);
        check("t5_capture_resumes", r, 32'h0001_0301);

        // ---- 6: byte-enable DIV update (CLR gated off), then disable mid-period ----
        bus_write(2'b10, 32'h0000_0502, 4'b0010);
        bus_read(2'b10, r);
        check("t6_div5", r, 32'h0001_0501);
        bus_write(2'b10, 32'h0000_0000, 4'b0001);
        check("t6_pwrdn", {31'b0, pwrdn}, 32'd1);
        check("t6_adcclk", {31'b0, adc_clk}, 32'd0);
        repeat (10) tick();
        check("t6_adcclk_idle", {31'b0, adc_clk}, 32'd0);
        bus_read(2'b10, r);
        check("t6_no_push", r, 32'h0001_0500);

        // ---- reset mid-operation ----
        do_reset();
        bus_read(2'b10, r);
        check("t7_reset_again", r, 32'h0000_0008);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
